// File: rtl/operand_loader.sv
// operand_loader: button-driven operand entry sequencer.
// Two raw pushbuttons are synchronized, debounced and edge-detected; the
// resulting one-cycle press events step a four-state FSM that captures
// operand A, operand B and the opcode from the switch bus in turn.
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] sw,
  input  logic        btn_next,
  input  logic        btn_clear,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [3:0]  op,
  output logic [1:0]  stage,
  output logic        ready,
  output logic        load_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Index 0 is the "next" button, index 1 the "clear" button.
  localparam int NEXT_IDX  = 0;
  localparam int CLEAR_IDX = 1;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    READY   = 2'd3
  } state_e;

  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    db_q, db_dly_q;
  logic [CW-1:0] cnt_q [2];
  logic [1:0]    press;

  state_e        state_q, state_d;
  logic [31:0]   operand_a_q, operand_a_d;
  logic [31:0]   operand_b_q, operand_b_d;
  logic [3:0]    op_q, op_d;
  logic          ready_q;
  logic          load_pulse_q, load_pulse_d;

  assign btn_raw = {btn_clear, btn_next};

  // Synchronize, debounce and delay both buttons; reset restarts debouncing.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      db_dly_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          db_q[i]  <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // One-cycle event on each debounced rising edge; releases are ignored.
  assign press = db_q & ~db_dly_q;

  // Next-state and capture logic; clear overrides next in the same cycle.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    operand_a_d  = operand_a_q;
    operand_b_d  = operand_b_q;
    op_d         = op_q;
    load_pulse_d = 1'b0;
    if (press[CLEAR_IDX]) begin
      state_d     = LOAD_A;
      operand_a_d = '0;
      operand_b_d = '0;
      op_d        = '0;
    end else if (press[NEXT_IDX]) begin
      case (state_q)
        LOAD_A: begin
          operand_a_d  = sw;
          load_pulse_d = 1'b1;
          state_d      = LOAD_B;
        end
        LOAD_B: begin
          operand_b_d  = sw;
          load_pulse_d = 1'b1;
          state_d      = LOAD_OP;
        end
        LOAD_OP: begin
          op_d         = sw[31:28];
          load_pulse_d = 1'b1;
          state_d      = READY;
        end
        READY:   state_d = LOAD_A;
        default: state_d = LOAD_A;
      endcase
    end
  end

  // FSM state, captured operands and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LOAD_A;
      operand_a_q  <= '0;
      operand_b_q  <= '0;
      op_q         <= '0;
      ready_q      <= 1'b0;
      load_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      operand_a_q  <= operand_a_d;
      operand_b_q  <= operand_b_d;
      op_q         <= op_d;
      ready_q      <= (state_d == READY);
      load_pulse_q <= load_pulse_d;
    end
  end

  assign operand_a  = operand_a_q;
  assign operand_b  = operand_b_q;
  assign op         = op_q;
  assign stage      = state_q;
  assign ready      = ready_q;
  assign load_pulse = load_pulse_q;

endmodule

// File: tb/tb_operand_loader.sv
// Testbench for operand_loader with DEBOUNCE_CYCLES=4. Stimulus pushes the
// expected post-capture snapshot into a queue; a monitor pops and compares
// whenever load_pulse is seen, and directed checks cover state after events.
module tb_operand_loader;

  localparam int DB = 4;

  typedef struct packed {
    logic [1:0]  stage;
    logic        ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sw;
  logic        btn_next;
  logic        btn_clear;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [3:0]  op;
  logic [1:0]  stage;
  logic        ready;
  logic        load_pulse;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;
  snap_t exp_q[$];

  operand_loader #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw         (sw),
    .btn_next   (btn_next),
    .btn_clear  (btn_clear),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .op         (op),
    .stage      (stage),
    .ready      (ready),
    .load_pulse (load_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] st, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] o);
    snap_t s;
    s.stage = st;
    s.ready = (st == 2'd3);
    s.a     = a;
    s.b     = b;
    s.op    = o;
    exp_q.push_back(s);
  endtask

  // Press "next" for hold cycles, then release and let the release settle.
  task automatic press_next(input int hold);
    btn_next = 1'b1;
    tick(hold);
    btn_next = 1'b0;
    tick(15);
  endtask

  task automatic press_clear();
    btn_clear = 1'b1;
    tick(10);
    btn_clear = 1'b0;
    tick(15);
  endtask

  task automatic check_state(input string name, input logic [1:0] st, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] o);
    snap_t want;
    snap_t got;
    want = '{stage: st, ready: (st == 2'd3), a: a, b: b, op: o};
    got  = '{stage: stage, ready: ready, a: operand_a, b: operand_b, op: op};
    check(name, 72'(got), 72'(want));
  endtask

  // Scoreboard monitor: every load_pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && load_pulse === 1'b1) begin
      snap_t got;
      got = '{stage: stage, ready: ready, a: operand_a, b: operand_b, op: op};
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_load_pulse", 72'(load_pulse), 72'(0));
      end else begin
        check("capture", 72'(got), 72'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int p0;
    rst_n     = 1'b0;
    sw        = 32'h1234_5678;
    btn_next  = 1'b1;
    btn_clear = 1'b0;

    // 1. Reset with next held; one capture exactly 7 edges after release.
    tick(3);
    check_state("reset_state", 2'd0, 32'h0, 32'h0, 4'h0);
    check("reset_load_pulse", 72'(load_pulse), 72'(0));
    push(2'd1, 32'h1234_5678, 32'h0, 4'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      check($sformatf("post_reset_edge%0d_pulse", i), 72'(load_pulse), 72'(i == 7));
    end
    tick(20);
    btn_next = 1'b0;
    tick(15);
    check_state("held_after_reset", 2'd1, 32'h1234_5678, 32'h0, 4'h0);
    press_clear();
    check_state("clear_from_load_b", 2'd0, 32'h0, 32'h0, 4'h0);

    // 2. Full sequence; sw changes outside captures must be ignored.
    p0 = pulse_cnt;
    sw = 32'h0000_0005; push(2'd1, 32'h5, 32'h0, 4'h0);
    btn_next = 1'b1; tick(20); btn_next = 1'b0; sw = 32'hDEAD_BEEF; tick(15);
    sw = 32'h0000_0003; push(2'd2, 32'h5, 32'h3, 4'h0);
    btn_next = 1'b1; tick(20); btn_next = 1'b0; sw = 32'hDEAD_BEEF; tick(15);
    sw = 32'h2000_0000; push(2'd3, 32'h5, 32'h3, 4'h2);
    btn_next = 1'b1; tick(20); btn_next = 1'b0; sw = 32'hDEAD_BEEF; tick(15);
    check_state("full_sequence", 2'd3, 32'h5, 32'h3, 4'h2);
    check("full_sequence_pulses", 72'(pulse_cnt - p0), 72'(3));

    // 5. READY wrap keeps operands, next press reloads A.
    p0 = pulse_cnt;
    sw = 32'hFFFF_FFFF;
    press_next(20);
    check_state("ready_wrap", 2'd0, 32'h5, 32'h3, 4'h2);
    check("ready_wrap_no_pulse", 72'(pulse_cnt - p0), 72'(0));
    push(2'd1, 32'hFFFF_FFFF, 32'h3, 4'h2);
    press_next(20);
    check_state("reload_a", 2'd1, 32'hFFFF_FFFF, 32'h3, 4'h2);

    // 3. Glitch rejection in LOAD_A.
    press_clear();
    check_state("clear_before_glitch", 2'd0, 32'h0, 32'h0, 4'h0);
    p0 = pulse_cnt;
    sw = 32'h0000_00A5;
    press_next(3);
    check_state("glitch_3cyc", 2'd0, 32'h0, 32'h0, 4'h0);
    check("glitch_3cyc_pulses", 72'(pulse_cnt - p0), 72'(0));
    push(2'd1, 32'hA5, 32'h0, 4'h0);
    btn_next = 1'b1; tick(5);
    btn_next = 1'b0; tick(1);
    btn_next = 1'b1; tick(4);
    btn_next = 1'b0; tick(15);
    check_state("press_with_drop", 2'd1, 32'hA5, 32'h0, 4'h0);
    check("press_with_drop_pulses", 72'(pulse_cnt - p0), 72'(1));

    // 4. Clear and next land together in LOAD_OP: clear wins.
    sw = 32'h0000_0077; push(2'd2, 32'hA5, 32'h77, 4'h0);
    press_next(20);
    check_state("reach_load_op", 2'd2, 32'hA5, 32'h77, 4'h0);
    p0 = pulse_cnt;
    sw = 32'hF000_0000;
    btn_next = 1'b1; btn_clear = 1'b1;
    tick(10);
    btn_next = 1'b0; btn_clear = 1'b0;
    tick(15);
    check_state("clear_priority", 2'd0, 32'h0, 32'h0, 4'h0);
    check("clear_priority_pulses", 72'(pulse_cnt - p0), 72'(0));

    // 6. Long hold gives a single capture.
    p0 = pulse_cnt;
    sw = 32'h0BAD_F00D; push(2'd1, 32'h0BAD_F00D, 32'h0, 4'h0);
    press_next(200);
    check_state("long_hold", 2'd1, 32'h0BAD_F00D, 32'h0, 4'h0);
    check("long_hold_pulses", 72'(pulse_cnt - p0), 72'(1));

    check("scoreboard_drained", 72'(exp_q.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
# operand_loader

Button-driven operand entry sequencer feeding the ALU datapath. Samples a 32-bit switch bus under control of a debounced "next" button, capturing operand A, operand B and the 4-bit opcode in turn. All state is held in registers clocked by the single system clock, so downstream logic never sees button edges used as clocks. Its outputs drive the ALU operand and opcode inputs directly; `ready` marks a complete operand set.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 20000: consecutive cycles a synchronized button level must differ from the debounced level before the debounced level changes. Minimum legal value is 1.

Ports:
- `clk`  input  1  system clock; all logic on rising edge
- `rst_n`  input  1  synchronous, active-low reset
- `sw`  input  32  raw switch bus; sampled directly, no synchronizer
- `btn_next`  input  1  raw "next" pushbutton, asynchronous, active-high
- `btn_clear`  input  1  raw "clear" pushbutton, asynchronous, active-high
- `operand_a`  output  32  captured operand A
- `operand_b`  output  32  captured operand B
- `op`  output  4  captured opcode
- `stage`  output  2  current state: 0 LOAD_A, 1 LOAD_B, 2 LOAD_OP, 3 READY
- `ready`  output  1  high in READY
- `load_pulse`  output  1  one-cycle strobe on every capture

## Operation

- Each button passes through its own chain:
  - 2-flop synchronizer.
  - Debounce counter `cnt`:
    - When the synchronized level equals the debounced level `db`, `cnt` is 0.
    - Otherwise `cnt` increments each cycle.
    - On the cycle where `cnt == DEBOUNCE_CYCLES-1` and a mismatch persists, `db` takes the synchronized level and `cnt` returns to 0.
    - Any return to agreement before that point zeroes `cnt` (glitch rejected).
  - `db_d` is `db` delayed one cycle.
  - Press event `press = db & ~db_d`, high exactly one cycle per debounced rising edge. A release generates no event.
- FSM, acting on `next = press(btn_next)` and `clear = press(btn_clear)`:
  - LOAD_A on next: `operand_a <= sw`, go to LOAD_B.
  - LOAD_B on next: `operand_b <= sw`, go to LOAD_OP.
  - LOAD_OP on next: `op <= sw[31:28]`, go to READY.
  - READY on next: go to LOAD_A. All captured registers are retained; no capture, `load_pulse` stays low.
  - `clear` in any state: go to LOAD_A and zero `operand_a`, `operand_b`, `op`. `load_pulse` stays low.
  - `clear` and `next` in the same cycle: `clear` wins and `next` is discarded.
- `load_pulse` is registered. It is high for the cycle after each capture (LOAD_A, LOAD_B, LOAD_OP transitions only).
- `ready = (stage == 3)`, registered alongside `stage`.
- Held buttons produce one event per press, regardless of hold length.

## Timing

- Reset (`rst_n` low at a rising edge) sets the following; it takes priority over all events:
  - `operand_a = 0`, `operand_b = 0`, `op = 0`, `stage = 0`, `ready = 0`, `load_pulse = 0`.
  - All synchronizers, `db`, `db_d` and `cnt` = 0.
- Reset mid-debounce discards the partial count. A button still held after reset must be debounced again from zero and then produces one press.
- Latency for a raw button rising at edge 0 and held stable:
  - Synchronized level valid after edge 2.
  - `db` rises at edge 2+DEBOUNCE_CYCLES.
  - `press` is high during the following cycle.
  - Capture, state change and `ready` update occur at edge 3+DEBOUNCE_CYCLES.
  - `load_pulse` is high for the cycle after that edge.
- `sw` is sampled at the capture edge only. Changes at other times have no effect.
- Minimum spacing between two accepted presses is bounded by debounce of the release plus the next press: 2×DEBOUNCE_CYCLES cycles.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.

1. Reset behaviour: `rst_n=0` for 3 cycles with `btn_next` held high, then release reset.
   - All outputs 0 and `stage=0` during reset.
   - After reset: exactly one capture, occurring 7 cycles after reset deassertion.
2. Full sequence with clean 20-cycle presses:
   - `sw=0x0000_0005` press, `sw=0x0000_0003` press, `sw=0x2000_0000` press.
   - Required: `operand_a=5`, `operand_b=3`, `op=2`, `stage=3`, `ready=1`, and exactly three `load_pulse`s.
3. Glitch rejection:
   - `btn_next` pulses of 3 cycles, and a 10-cycle press with a 1-cycle mid-press drop, both during LOAD_A.
   - Required: the 3-cycle pulse causes no capture. The 10-cycle press captures once at most and the drop produces no second press.
4. Clear priority:
   - In LOAD_OP with `op` still 0, assert `btn_clear` and `btn_next` so both debounced edges land in the same cycle.
   - Required: `stage=0`, all operands 0, no `load_pulse`.
5. READY wrap:
   - From scenario 2, press next with `sw=0xFFFF_FFFF`.
   - Required: `stage=0`, `ready=0`, `operand_a` still 5.
   - A further press loads `0xFFFF_FFFF` into `operand_a`.
6. Long hold: hold `btn_next` for 200 cycles. Required: exactly one capture, one `load_pulse`, one stage advance.
